// File: rtl/ir_pulse_decoder.sv
// IR pulse-width decoder: start mark followed by NUM_BITS data marks, LSB first.
// Optional 8-sample input glitch filter enabled by defining IR_GLITCH_FILTER_EN.
module ir_pulse_decoder #(
  parameter int unsigned CLK_IN_FREQ = 100_000_000,
  parameter int unsigned START_US    = 2000,
  parameter int unsigned ONE_US      = 1100,
  parameter int unsigned ZERO_US     = 550,
  parameter int unsigned TOL_US      = 150,
  parameter int unsigned TIMEOUT_US  = 3000,
  parameter int unsigned NUM_BITS    = 4
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                IR_IN,
  output logic [NUM_BITS-1:0] CMD_OUT,
  output logic                CMD_VALID,
  output logic                FRAME_ERR,
  output logic                BUSY
);

  localparam int unsigned Div     = (CLK_IN_FREQ / 1_000_000 > 0) ? CLK_IN_FREQ / 1_000_000 : 1;
  localparam int unsigned PresW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitW    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(Div - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(NUM_BITS - 1);

  localparam int unsigned StartLo = (START_US > TOL_US) ? START_US - TOL_US : 0;
  localparam int unsigned StartHi = START_US + TOL_US;
  localparam int unsigned OneLo   = (ONE_US > TOL_US) ? ONE_US - TOL_US : 0;
  localparam int unsigned OneHi   = ONE_US + TOL_US;
  localparam int unsigned ZeroLo  = (ZERO_US > TOL_US) ? ZERO_US - TOL_US : 0;
  localparam int unsigned ZeroHi  = ZERO_US + TOL_US;

  typedef enum logic [2:0] {
    StIdle,
    StStartMark,
    StStartSpace,
    StDataMark,
    StDataSpace
  } state_e;

  logic sync1_q, sync2_q;
  logic lvl, lvl_q;
  logic fall, rise, edge_det;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= IR_IN;
      sync2_q <= sync1_q;
    end
  end

`ifdef IR_GLITCH_FILTER_EN
  logic [2:0] flt_cnt_q;
  logic       flt_lvl_q;

  // A new level is adopted on the 8th consecutive sample that disagrees with the current one.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      flt_cnt_q <= 3'd0;
      flt_lvl_q <= 1'b1;
    end else if (sync2_q == flt_lvl_q) begin
      flt_cnt_q <= 3'd0;
    end else if (flt_cnt_q == 3'd7) begin
      flt_cnt_q <= 3'd0;
      flt_lvl_q <= sync2_q;
    end else begin
      flt_cnt_q <= flt_cnt_q + 3'd1;
    end
  end

  assign lvl = flt_lvl_q;
`else
  assign lvl = sync2_q;
`endif

  assign fall     = lvl_q & ~lvl;
  assign rise     = ~lvl_q & lvl;
  assign edge_det = fall | rise;

  logic [PresW-1:0] pres_q;
  logic [15:0]      us_q, us_inc;
  logic             tick;

  assign tick   = (pres_q == PresMax);
  assign us_inc = (tick && us_q != 16'hFFFF) ? us_q + 16'd1 : us_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lvl_q  <= 1'b1;
      pres_q <= '0;
      us_q   <= '0;
    end else begin
      lvl_q <= lvl;
      if (edge_det || tick) begin
        pres_q <= '0;
      end else begin
        pres_q <= pres_q + PresW'(1);
      end
      us_q <= edge_det ? 16'd0 : us_inc;
    end
  end

  // Width including the tick of the current cycle, so an exact N us pulse measures N.
  logic [31:0] width;
  logic        start_ok, is_one, is_zero, timeout;

  state_e              state_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [NUM_BITS-1:0] shreg_q, shift_next;
  logic [NUM_BITS:0]   shift_cat;

  assign width     = {16'd0, us_inc};
  assign start_ok  = (width >= StartLo) && (width <= StartHi);
  assign is_one    = (width >= OneLo) && (width <= OneHi);
  assign is_zero   = (width >= ZeroLo) && (width <= ZeroHi);
  assign timeout   = (state_q != StIdle) && (width > TIMEOUT_US);
  assign shift_cat = {is_one, shreg_q};
  assign shift_next = shift_cat[NUM_BITS:1];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      CMD_OUT   <= '0;
      CMD_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      CMD_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (timeout) begin
        FRAME_ERR <= 1'b1;
        state_q   <= StIdle;
        BUSY      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fall) begin
              state_q <= StStartMark;
              BUSY    <= 1'b1;
            end
          end
          StStartMark: begin
            if (rise) begin
              if (start_ok) begin
                state_q   <= StStartSpace;
                bit_cnt_q <= '0;
              end else begin
                FRAME_ERR <= 1'b1;
                state_q   <= StIdle;
                BUSY      <= 1'b0;
              end
            end
          end
          StStartSpace, StDataSpace: begin
            if (fall) state_q <= StDataMark;
          end
          StDataMark: begin
            if (rise) begin
              if (is_one || is_zero) begin
                shreg_q <= shift_next;
                if (bit_cnt_q == LastBit) begin
                  CMD_OUT   <= shift_next;
                  CMD_VALID <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= StIdle;
                  BUSY      <= 1'b0;
                end else begin
                  bit_cnt_q <= bit_cnt_q + BitW'(1);
                  state_q   <= StDataSpace;
                end
              end else begin
                FRAME_ERR <= 1'b1;
                state_q   <= StIdle;
                BUSY      <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ir_pulse_decoder.md
IR_PULSE_DECODER -- requirements
Module: ir_pulse_decoder

Interface
REQ-001 SHALL have parameter CLK_IN_FREQ, default 100_000_000, CLK frequency in Hz.
REQ-002 SHALL have parameter START_US, default 2000, nominal start-mark width in us.
REQ-003 SHALL have parameter ONE_US, default 1100, nominal logic-1 mark width in us.
REQ-004 SHALL have parameter ZERO_US, default 550, nominal logic-0 mark width in us.
REQ-005 SHALL have parameter TOL_US, default 150, +/- acceptance window in us for every mark class.
REQ-006 SHALL have parameter TIMEOUT_US, default 3000, maximum mark or space width in us inside a frame.
REQ-007 SHALL have parameter NUM_BITS, default 4, data bits per frame.
REQ-008 SHALL have port CLK  input  1  system clock.
REQ-009 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port IR_IN  input  1  demodulated receiver output, asynchronous; low = mark (carrier present).
REQ-011 SHALL have port CMD_OUT  output  NUM_BITS  last good decoded command, held until the next good frame.
REQ-012 SHALL have port CMD_VALID  output  1  one-CLK pulse when CMD_OUT updates.
REQ-013 SHALL have port FRAME_ERR  output  1  one-CLK pulse when a frame is aborted.
REQ-014 SHALL have port BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass IR_IN through a 2-flop synchronizer; edges are detected on the synchronized (optionally filtered) signal.
REQ-016 SHALL generate a 1 us tick from a prescaler counting 0..CLK_IN_FREQ/1_000_000-1, free-running, restarted on every accepted edge.
REQ-017 SHALL measure each mark/space in a 16-bit us counter, cleared on every accepted edge, saturating at 0xFFFF.
REQ-018 SHALL implement FSM states IDLE, START_MARK, START_SPACE, DATA_MARK, DATA_SPACE.
REQ-019 IDLE -> START_MARK on falling edge; START_MARK -> START_SPACE on rising edge if width within START_US+/-TOL_US, else FRAME_ERR and IDLE.
REQ-020 START_SPACE/DATA_SPACE -> DATA_MARK on falling edge; DATA_MARK ends on rising edge.
REQ-021 Data mark within ONE_US+/-TOL_US SHALL decode 1; within ZERO_US+/-TOL_US SHALL decode 0; otherwise FRAME_ERR, IDLE, CMD_OUT unchanged.
REQ-022 Window bounds SHALL be inclusive; overlapping windows resolve to 1.
REQ-023 Bits SHALL be shifted in LSB first (first data mark -> CMD_OUT[0]).
REQ-024 After the NUM_BITS-th good data mark: CMD_OUT loaded, CMD_VALID pulsed, FSM -> IDLE, within 2 CLK of the terminating rising edge.
REQ-025 Otherwise after a good data mark FSM -> DATA_SPACE.
REQ-026 Any mark or space in a non-IDLE state exceeding TIMEOUT_US SHALL pulse FRAME_ERR and return to IDLE; IDLE never times out.
REQ-027 CMD_VALID and FRAME_ERR SHALL never assert in the same cycle; each is exactly one CLK wide.
REQ-028 A falling edge arriving in the same cycle as a return to IDLE SHALL be ignored; the next frame starts on a subsequent falling edge.

Reset
REQ-029 On RESETN low, asynchronously: FSM = IDLE, CMD_OUT = 0, CMD_VALID = 0, FRAME_ERR = 0, BUSY = 0, all counters/shift register = 0, synchronizer flops = 1.
REQ-030 Reset mid-frame SHALL discard the partial frame without pulsing FRAME_ERR.

Configuration
REQ-031 Macro IR_GLITCH_FILTER_EN defined: synchronized input SHALL be accepted as a new level only after 8 consecutive identical CLK samples (8-CLK added latency, pulses < 8 CLK rejected).
REQ-032 Macro IR_GLITCH_FILTER_EN undefined: synchronized input SHALL be used directly; no filter logic present.

Verification
REQ-033 Marks 2000/1100/550/1100/550 us, 600 us spaces -> CMD_VALID once, CMD_OUT = 4'b0101, no FRAME_ERR.
REQ-034 Start mark 1500 us -> FRAME_ERR once at its rising edge, CMD_OUT unchanged, BUSY = 0 after.
REQ-035 Valid start + 2 bits, then IR_IN high 3500 us -> FRAME_ERR at ~3001 us into space, no CMD_VALID.
REQ-036 Data mark 800 us -> FRAME_ERR; boundary marks 950 us and 700 us -> decode 1 and 0 respectively.
REQ-037 RESETN low at start of third data mark, released, full 4'b1111 frame sent -> no FRAME_ERR, CMD_VALID with CMD_OUT = 4'b1111.
REQ-038 With IR_GLITCH_FILTER_EN, 5-CLK low glitches injected every 100 us during spaces of REQ-033 frame -> CMD_OUT = 4'b0101, no FRAME_ERR.
